// File: rtl/meta_arbiter_pkg.sv
// Shared types for the flow-director metadata path: metadata word, arbiter quota config
// and default constants.
package meta_arbiter_pkg;

  localparam int META_ARB_NB_INPUTS     = 4;
  localparam int META_ARB_QUOTA_W       = 8;
  localparam int META_ARB_DEFAULT_QUOTA = 1;

  typedef struct packed {
    logic [31:0] flow_hash;
    logic [15:0] pkt_len;
    logic [7:0]  pkt_queue_id;
    logic [7:0]  pkt_flags;
  } metadata_t;

  // One burst quota per input, input 0 in the least-significant field.
  typedef logic [META_ARB_NB_INPUTS-1:0][META_ARB_QUOTA_W-1:0] meta_arb_config_t;

endpackage

// File: rtl/rr_prio_sel.sv
// Combinational rotating-priority encoder: first set request at or after start, wrapping.
// Returns one-hot grant, its index and an any-request flag.
module rr_prio_sel #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!vld && req[(int'(start) + k) % N]) begin
        vld = 1'b1;
        idx = IW'((int'(start) + k) % N);
        gnt[(int'(start) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/meta_arbiter.sv
// Weighted round-robin arbiter onto a registered single-entry metadata output stage;
// 1-cycle latency, full throughput. META_ARB_STATS_EN adds per-input grant counters.
module meta_arbiter
  import meta_arbiter_pkg::*;
#(
  parameter int NB_INPUTS = META_ARB_NB_INPUTS,
  parameter int QUOTA_W   = META_ARB_QUOTA_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  metadata_t [NB_INPUTS-1:0]         in_meta_data,
  input  logic [NB_INPUTS-1:0]              in_meta_valid,
  output logic [NB_INPUTS-1:0]              in_meta_ready,
  output metadata_t                         out_meta_data,
  output logic                              out_meta_valid,
  input  logic                              out_meta_ready,
  input  logic [NB_INPUTS-1:0][QUOTA_W-1:0] conf_arb_data,
  input  logic                              conf_arb_valid,
  output logic                              conf_arb_ready
`ifdef META_ARB_STATS_EN
  ,
  input  logic                              stats_clear,
  output logic [NB_INPUTS-1:0][31:0]        stats_grant_cnt
`endif
);

  localparam int IW = (NB_INPUTS > 1) ? $clog2(NB_INPUTS) : 1;
  localparam int CW = QUOTA_W + 1;

  logic [IW-1:0]                     ptr;
  logic [CW-1:0]                     cnt;
  logic [NB_INPUTS-1:0][QUOTA_W-1:0] quota;

  logic [QUOTA_W-1:0]   cur_quota;
  logic                 stay;
  logic [IW-1:0]        rot_start;
  logic [NB_INPUTS-1:0] rot_gnt;
  logic [IW-1:0]        rot_idx;
  logic                 rot_vld;
  logic [IW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic                 load_en;
  logic                 xfer;
  logic [CW-1:0]        cnt_nxt;

  assign conf_arb_ready = 1'b1;
  assign load_en        = !out_meta_valid || out_meta_ready;

  // A programmed quota of zero would starve the owner; treat it as one.
  assign cur_quota = (quota[ptr] == '0) ? QUOTA_W'(1) : quota[ptr];
  assign stay      = in_meta_valid[ptr] && (cnt < {1'b0, cur_quota});
  assign rot_start = (ptr == IW'(NB_INPUTS - 1)) ? '0 : ptr + IW'(1);

  // Scan starts after ptr and ends on ptr, so a lone requester is re-granted.
  rr_prio_sel #(.N(NB_INPUTS), .IW(IW)) u_rot (
    .req   (in_meta_valid),
    .start (rot_start),
    .gnt   (rot_gnt),
    .idx   (rot_idx),
    .vld   (rot_vld)
  );

  assign gnt_idx = stay ? ptr : rot_idx;
  assign gnt_any = stay || rot_vld;
  assign xfer    = !rst && load_en && gnt_any;

  always_comb begin
    in_meta_ready = '0;
    if (xfer) begin
      in_meta_ready = stay ? (NB_INPUTS'(1) << ptr) : rot_gnt;
    end
  end

  always_comb begin
    cnt_nxt = CW'(1);
    if (stay) begin
      cnt_nxt = (&cnt) ? cnt : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_meta_valid <= 1'b0;
      out_meta_data  <= '0;
      ptr            <= '0;
      cnt            <= '0;
      for (int i = 0; i < NB_INPUTS; i++) begin
        quota[i] <= QUOTA_W'(META_ARB_DEFAULT_QUOTA);
      end
    end else begin
      if (load_en) begin
        if (gnt_any) begin
          out_meta_data  <= in_meta_data[gnt_idx];
          out_meta_valid <= 1'b1;
          ptr            <= gnt_idx;
          cnt            <= cnt_nxt;
        end else begin
          out_meta_valid <= 1'b0;
        end
      end
      // Config restarts the owner's burst, overriding any same-edge increment.
      if (conf_arb_valid) begin
        quota <= conf_arb_data;
        cnt   <= '0;
      end
    end
  end

`ifdef META_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clear) begin
      stats_grant_cnt <= '0;
    end else if (xfer) begin
      stats_grant_cnt[gnt_idx] <= stats_grant_cnt[gnt_idx] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_meta_arbiter.sv
// Directed table-driven bench for meta_arbiter; stats section runs when META_ARB_STATS_EN is set.
module tb_meta_arbiter;
  import meta_arbiter_pkg::*;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst;
  metadata_t [N-1:0]   in_meta_data;
  logic [N-1:0]        in_meta_valid;
  logic [N-1:0]        in_meta_ready;
  metadata_t           out_meta_data;
  logic                out_meta_valid;
  logic                out_meta_ready;
  logic [N-1:0][7:0]   conf_arb_data;
  logic                conf_arb_valid;
  logic                conf_arb_ready;
`ifdef META_ARB_STATS_EN
  logic                stats_clear;
  logic [N-1:0][31:0]  stats_grant_cnt;
`endif

  meta_arbiter #(.NB_INPUTS(N), .QUOTA_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_meta_data   (in_meta_data),
    .in_meta_valid  (in_meta_valid),
    .in_meta_ready  (in_meta_ready),
    .out_meta_data  (out_meta_data),
    .out_meta_valid (out_meta_valid),
    .out_meta_ready (out_meta_ready),
    .conf_arb_data  (conf_arb_data),
    .conf_arb_valid (conf_arb_valid),
    .conf_arb_ready (conf_arb_ready)
`ifdef META_ARB_STATS_EN
    ,
    .stats_clear    (stats_clear),
    .stats_grant_cnt(stats_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      vld;
    logic            ordy;
    logic            cfg;
    logic [3:0][7:0] q;
    logic [3:0]      exp_rdy;
    logic            exp_ov;
  } vec_t;

  vec_t      tbl[$];
  int        compared = 0;
  int        mismatched = 0;
  int        drv_seq[N];
  int        exp_seq[N];
  metadata_t exp_word;

  function automatic metadata_t mk(input int i, input int s);
    metadata_t m;
    m.flow_hash    = {4'hA, 4'(i), 8'h00, 16'(s)};
    m.pkt_len      = 16'h0040 + 16'(s);
    m.pkt_queue_id = 8'(i);
    m.pkt_flags    = 8'h80 | 8'(i);
    return m;
  endfunction

  function automatic vec_t r(input logic [3:0] vld, input logic ordy, input logic cfg,
                             input logic [31:0] q, input logic [3:0] exp_rdy, input logic exp_ov);
    vec_t v;
    v.vld = vld; v.ordy = ordy; v.cfg = cfg; v.q = q; v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) in_meta_data[i] = mk(i, drv_seq[i]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic step(input int idx, input vec_t v);
    logic [N-1:0] xfer;
    logic [N-1:0] exp_x;
    in_meta_valid  = v.vld;
    out_meta_ready = v.ordy;
    conf_arb_valid = v.cfg;
    conf_arb_data  = v.q;
    #3;
    check($sformatf("row%0d in_meta_ready", idx), 64'(in_meta_ready), 64'(v.exp_rdy));
    xfer  = in_meta_valid & in_meta_ready;
    exp_x = v.vld & v.exp_rdy;
    for (int k = 0; k < N; k++) begin
      if (exp_x[k]) begin
        exp_word = mk(k, exp_seq[k]);
        exp_seq[k]++;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (xfer[k]) drv_seq[k]++;
    conf_arb_valid = 1'b0;
    check($sformatf("row%0d out_meta_valid", idx), 64'(out_meta_valid), 64'(v.exp_ov));
    if (v.exp_ov) check($sformatf("row%0d out_meta_data", idx), out_meta_data, exp_word);
  endtask

  localparam logic [31:0] Q1 = {8'd1, 8'd1, 8'd0, 8'd3};
  localparam logic [31:0] Q2 = {8'd2, 8'd2, 8'd2, 8'd2};

  initial begin
    for (int i = 0; i < N; i++) begin drv_seq[i] = 0; exp_seq[i] = 0; end
    exp_word       = '0;
    rst            = 1'b1;
    in_meta_valid  = 4'b1111;
    out_meta_ready = 1'b1;
    conf_arb_valid = 1'b0;
    conf_arb_data  = '0;
`ifdef META_ARB_STATS_EN
    stats_clear    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset in_meta_ready", 64'(in_meta_ready), 64'd0);
    check("reset out_meta_valid", 64'(out_meta_valid), 64'd0);
    check("reset out_meta_data", out_meta_data, 64'd0);
    check("conf_arb_ready", 64'(conf_arb_ready), 64'd1);
    rst = 1'b0;

    // Plain round-robin with default quotas.
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0001, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0010, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0100, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b1000, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0001, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0010, 1));
    // Downstream stall: nothing accepted, output held; resumes at ptr+1.
    for (int i = 0; i < 5; i++) tbl.push_back(r(4'b1111, 0, 0, 0, 4'b0000, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0100, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b1000, 1));
    // Lone requester: back-to-back grants.
    for (int i = 0; i < 3; i++) tbl.push_back(r(4'b0100, 1, 0, 0, 4'b0100, 1));
    tbl.push_back(r(4'b0000, 1, 0, 0, 4'b0000, 0));
    // Quotas {3,0,1,1}; owner is input 2 with a fresh burst.
    tbl.push_back(r(4'b0000, 1, 1, Q1, 4'b0000, 0));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0100, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b1000, 1));
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 3; i++) tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0001, 1));
      tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0010, 1));
      if (rep == 0) begin
        tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0100, 1));
        tbl.push_back(r(4'b1111, 1, 0, 0, 4'b1000, 1));
      end
    end
    // Config during stall restarts input 1 at cnt 0: quota 0 must still grant once.
    tbl.push_back(r(4'b1111, 0, 1, Q1, 4'b0000, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0010, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0100, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b1000, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0001, 1));
    // Quotas {2,2,2,2} written mid-burst of input 0 (cnt=1): two more, then input 1.
    tbl.push_back(r(4'b1111, 0, 1, Q2, 4'b0000, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0001, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0001, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0010, 1));
    // Config on the same edge as a transfer: counter forced to 0, not incremented.
    tbl.push_back(r(4'b1111, 1, 1, Q2, 4'b0010, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0010, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0010, 1));
    tbl.push_back(r(4'b1111, 1, 0, 0, 4'b0100, 1));

    foreach (tbl[i]) step(i, tbl[i]);

`ifdef META_ARB_STATS_EN
    stats_clear = 1'b1;
    step(100, r(4'b0000, 1, 0, 0, 4'b0000, 0));
    stats_clear = 1'b0;
    check("stats after clear", 64'(stats_grant_cnt[2]), 64'd0);
    for (int i = 0; i < 10; i++) step(101 + i, r(4'b1000, 1, 0, 0, 4'b1000, 1));
    check("stats in3 x10", 64'(stats_grant_cnt[3]), 64'd10);
    check("stats in0 idle", 64'(stats_grant_cnt[0]), 64'd0);
    stats_clear = 1'b1;
    step(111, r(4'b0000, 1, 0, 0, 4'b0000, 0));
    check("stats in3 cleared", 64'(stats_grant_cnt[3]), 64'd0);
    step(112, r(4'b1000, 1, 0, 0, 4'b1000, 1));
    stats_clear = 1'b0;
    check("stats clear beats xfer", 64'(stats_grant_cnt[3]), 64'd0);
    step(113, r(4'b1000, 1, 0, 0, 4'b1000, 1));
    check("stats in3 after clear", 64'(stats_grant_cnt[3]), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
